// File: rtl/hash_pkg.sv
// hash_pkg: shared bucket encoding, insert state encoding and table-index codes
package hash_pkg;

    localparam logic [3:0] EMPTY_CODE = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        WRITE
    } state_t;

    typedef enum logic [1:0] {
        TBL_NONE = 2'd0,
        TBL_1    = 2'd1,
        TBL_2    = 2'd2,
        TBL_3    = 2'd3
    } tbl_t;

    // Highest-priority empty bucket: table 1, then 2, then 3
    function automatic tbl_t pick_tbl(input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3);
        return d1 == EMPTY_CODE ? TBL_1 :
               d2 == EMPTY_CODE ? TBL_2 :
               d3 == EMPTY_CODE ? TBL_3 : TBL_NONE;
    endfunction

endpackage

// File: rtl/hash_rsp_capture.sv
// hash_rsp_capture: holds one table's read response; first valid after a clear wins, repeats are ignored
module hash_rsp_capture (
    input  logic       Sys_clk,
    input  logic       Rst,
    input  logic       Clr,
    input  logic       En,
    input  logic       Rsp_wr,
    input  logic [3:0] Rsp_data,
    output logic       Flag_nxt,
    output logic [3:0] Data_nxt
);

    logic       flag;
    logic [3:0] data;
    logic       take;

    // Next-state views let the controller act in the same cycle the last response lands
    always_comb begin
        take     = En & Rsp_wr & ~flag;
        Flag_nxt = ~Clr & (flag | take);
        Data_nxt = take ? Rsp_data : data;
    end

    // Response register and captured flag
    always_ff @(posedge Sys_clk or posedge Rst) begin
        if (Rst) begin
            flag <= 1'b0;
            data <= 4'd0;
        end else begin
            flag <= Flag_nxt;
            data <= Data_nxt;
        end
    end

endmodule

// File: rtl/hash_insert_ctrl.sv
// hash_insert_ctrl: three-way hash insert controller; define INSERT_TIMEOUT_EN to bound the response wait
module hash_insert_ctrl
    import hash_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              Sys_clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Insert_addr1,
    input  logic [ADDR_W-1:0] Insert_addr2,
    input  logic [ADDR_W-1:0] Insert_addr3,
    input  logic [3:0]        Insert_data,
    input  logic              Insert_wr,
    output logic              Insert_rdy,
    output logic [ADDR_W-1:0] Hash_raddr1,
    output logic [ADDR_W-1:0] Hash_raddr2,
    output logic [ADDR_W-1:0] Hash_raddr3,
    output logic              Hash_rd1,
    output logic              Hash_rd2,
    output logic              Hash_rd3,
    input  logic [3:0]        Hash_rdata1,
    input  logic [3:0]        Hash_rdata2,
    input  logic [3:0]        Hash_rdata3,
    input  logic              Hash_rdata1_wr,
    input  logic              Hash_rdata2_wr,
    input  logic              Hash_rdata3_wr,
    output logic [ADDR_W-1:0] Hash_waddr1,
    output logic [ADDR_W-1:0] Hash_waddr2,
    output logic [ADDR_W-1:0] Hash_waddr3,
    output logic [3:0]        Hash_wdata1,
    output logic [3:0]        Hash_wdata2,
    output logic [3:0]        Hash_wdata3,
    output logic              Hash_wr1,
    output logic              Hash_wr2,
    output logic              Hash_wr3,
    output logic              Insert_done_wr,
    output logic [1:0]        Insert_done_tbl,
    output logic              Insert_done_err
);

    state_t     state, state_nxt;
    tbl_t       sel, tbl_nxt;
    logic [3:0] data_r;
    logic [3:0] d1, d2, d3;
    logic       f1, f2, f3;
    logic       clr, en, acc, all_rsp, timeout;
    logic       rd_nxt, done_nxt, err_nxt;
    logic [2:0] wr_nxt;

    hash_rsp_capture u_rsp1 (
        .Sys_clk (Sys_clk),
        .Rst     (Rst),
        .Clr     (clr),
        .En      (en),
        .Rsp_wr  (Hash_rdata1_wr),
        .Rsp_data(Hash_rdata1),
        .Flag_nxt(f1),
        .Data_nxt(d1)
    );

    hash_rsp_capture u_rsp2 (
        .Sys_clk (Sys_clk),
        .Rst     (Rst),
        .Clr     (clr),
        .En      (en),
        .Rsp_wr  (Hash_rdata2_wr),
        .Rsp_data(Hash_rdata2),
        .Flag_nxt(f2),
        .Data_nxt(d2)
    );

    hash_rsp_capture u_rsp3 (
        .Sys_clk (Sys_clk),
        .Rst     (Rst),
        .Clr     (clr),
        .En      (en),
        .Rsp_wr  (Hash_rdata3_wr),
        .Rsp_data(Hash_rdata3),
        .Flag_nxt(f3),
        .Data_nxt(d3)
    );

`ifdef INSERT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    assign timeout = wait_cnt == CNT_W'(TIMEOUT);

    // Saturating wait counter, restarted every time WAIT is entered
    always_ff @(posedge Sys_clk or posedge Rst) begin
        if (Rst)
            wait_cnt <= '0;
        else if (state != WAIT)
            wait_cnt <= '0;
        else if (!timeout)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0 & (TIMEOUT != 0);
`endif

    assign acc     = state == IDLE && Insert_wr;
    assign all_rsp = f1 & f2 & f3;
    assign sel     = pick_tbl(d1, d2, d3);

    // Next state plus the values every registered output takes on the next edge
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        en        = 1'b0;
        rd_nxt    = 1'b0;
        wr_nxt    = 3'b000;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        tbl_nxt   = TBL_NONE;
        case (state)
            IDLE: if (Insert_wr) begin
                state_nxt = Insert_data == EMPTY_CODE ? WRITE : READ;
                rd_nxt    = Insert_data != EMPTY_CODE;
                done_nxt  = Insert_data == EMPTY_CODE;
                err_nxt   = Insert_data == EMPTY_CODE;
            end
            READ: begin
                clr       = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                en = 1'b1;
                if (all_rsp) begin
                    state_nxt = WRITE;
                    done_nxt  = 1'b1;
                    tbl_nxt   = sel;
                    wr_nxt    = {sel == TBL_3, sel == TBL_2, sel == TBL_1};
                end else if (timeout) begin
                    state_nxt = WRITE;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; read addresses double as the request address registers
    always_ff @(posedge Sys_clk or posedge Rst) begin
        if (Rst) begin
            state           <= IDLE;
            Insert_rdy      <= 1'b1;
            data_r          <= 4'd0;
            Hash_raddr1     <= '0;
            Hash_raddr2     <= '0;
            Hash_raddr3     <= '0;
            Hash_rd1        <= 1'b0;
            Hash_rd2        <= 1'b0;
            Hash_rd3        <= 1'b0;
            Hash_waddr1     <= '0;
            Hash_waddr2     <= '0;
            Hash_waddr3     <= '0;
            Hash_wdata1     <= 4'd0;
            Hash_wdata2     <= 4'd0;
            Hash_wdata3     <= 4'd0;
            Hash_wr1        <= 1'b0;
            Hash_wr2        <= 1'b0;
            Hash_wr3        <= 1'b0;
            Insert_done_wr  <= 1'b0;
            Insert_done_tbl <= 2'd0;
            Insert_done_err <= 1'b0;
        end else begin
            state           <= state_nxt;
            Insert_rdy      <= state_nxt == IDLE;
            Hash_rd1        <= rd_nxt;
            Hash_rd2        <= rd_nxt;
            Hash_rd3        <= rd_nxt;
            Hash_wr1        <= wr_nxt[0];
            Hash_wr2        <= wr_nxt[1];
            Hash_wr3        <= wr_nxt[2];
            Insert_done_wr  <= done_nxt;
            Insert_done_tbl <= tbl_nxt;
            Insert_done_err <= err_nxt;
            if (acc) begin
                Hash_raddr1 <= Insert_addr1;
                Hash_raddr2 <= Insert_addr2;
                Hash_raddr3 <= Insert_addr3;
                data_r      <= Insert_data;
            end
            if (done_nxt) begin
                Hash_waddr1 <= Hash_raddr1;
                Hash_waddr2 <= Hash_raddr2;
                Hash_waddr3 <= Hash_raddr3;
                Hash_wdata1 <= data_r;
                Hash_wdata2 <= data_r;
                Hash_wdata3 <= data_r;
            end
        end
    end

endmodule
